// File: rtl/cust_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cust_tx
//  Purpose  : Customer transmitter. Buffers host requests (service times) in
//             a small FIFO and emits them as one-cycle pulses with a ticket
//             number. Consecutive pulses are spaced by a programmable number
//             of idle cycles. Zero-time requests are discarded and counted.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             en                - permits starting new pulses
//             cfg_gap[3:0]      - idle cycles between consecutive pulses
//             req_valid/req_time/req_ready - request handshake
//             out_valid/out_num/out_time   - registered customer pulse
//             sent_cnt/drop_cnt - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module cust_tx #(
  parameter int DEPTH = 4  // FIFO depth in entries, 2..8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] cfg_gap,
  input  logic       req_valid,
  input  logic [3:0] req_time,
  output logic       req_ready,
  output logic       out_valid,
  output logic [3:0] out_num,
  output logic [3:0] out_time,
  output logic [7:0] sent_cnt,
  output logic [7:0] drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] C_LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // FSM and output registers
  state_t     state_q;
  logic [3:0] gcnt_q;
  logic [3:0] ticket_q;
  logic       out_valid_q;
  logic [3:0] out_num_q;
  logic [3:0] out_time_q;
  logic [7:0] sent_cnt_q;
  logic [7:0] drop_cnt_q;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_drop;
  logic w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (count_q == C_FULL_CNT);
  assign w_empty   = (count_q == '0);
  assign req_ready = !w_full;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && (req_time != 4'd0);
  assign w_drop    = w_accept && (req_time == 4'd0);

  // A pulse starts from IDLE, back-to-back from SEND when no gap is
  // configured, or on the last GAP cycle. A request pushed into an empty
  // FIFO in the same cycle is not visible until the next cycle.
  assign w_pop = en && !w_empty &&
                 ((state_q == S_IDLE) ||
                  ((state_q == S_SEND) && (cfg_gap == 4'd0)) ||
                  ((state_q == S_GAP)  && (gcnt_q == 4'd1)));

  always_comb begin
    wr_ptr_d = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= req_time;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gcnt_q      <= 4'd0;
      ticket_q    <= 4'd1;
      out_valid_q <= 1'b0;
      out_num_q   <= 4'd0;
      out_time_q  <= 4'd0;
      sent_cnt_q  <= 8'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      if (w_drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end

      if (w_pop) begin
        state_q     <= S_SEND;
        gcnt_q      <= 4'd0;
        out_valid_q <= 1'b1;
        out_num_q   <= ticket_q;
        out_time_q  <= mem_q[rd_ptr_q];
        // Ticket 0 is reserved: wrap 15 -> 1
        ticket_q    <= (ticket_q == 4'd15) ? 4'd1 : ticket_q + 4'd1;
        if (sent_cnt_q != 8'hFF) begin
          sent_cnt_q <= sent_cnt_q + 8'd1;
        end
      end else begin
        out_valid_q <= 1'b0;
        out_num_q   <= 4'd0;
        out_time_q  <= 4'd0;
        if ((state_q == S_SEND) && (cfg_gap != 4'd0)) begin
          state_q <= S_GAP;
          gcnt_q  <= cfg_gap;
        end else if ((state_q == S_GAP) && (gcnt_q != 4'd1)) begin
          // Gap runs to completion regardless of en
          gcnt_q <= gcnt_q - 4'd1;
        end else begin
          state_q <= S_IDLE;
          gcnt_q  <= 4'd0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_time  = out_time_q;
  assign sent_cnt  = sent_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire
